mmio_block_cipher_engine: RTL and testbench

- Memory-mapped byte-lane crypto coprocessor on the core's accelerator select/address/data bus.
- Holds an N_WORDS-word key block and plaintext block. On a GO write, it computes the ciphertext block byte-wise, LANES bytes per cycle, using a selectable operation: integer multiply low byte, GF(2^8) multiply, or XOR.
- Reports busy/done/error status, a cycle counter and a level interrupt to the core.

---
 rtl/mmio_bce_pkg.sv | 29 ++
 rtl/mmio_block_cipher_engine_gf_mul8.sv | 26 ++
 rtl/mmio_block_cipher_engine.sv | 194 +++++++++++++++++++
 tb/tb_mmio_block_cipher_engine.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bce_pkg.sv
// rtl/mmio_bce_pkg.sv - shared constants, mode encoding and register map for the block cipher engine
package mmio_bce_pkg;

    localparam int IDX_CTRL     = 8;
    localparam int IDX_COUNT    = 9;
    localparam int IDX_KEY_BASE = 10;

    localparam logic [7:0] AES_POLY = 8'h1B;

    localparam int CTRL_GO       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IRQ_EN   = 3;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'd0,
        MODE_GF   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    function automatic int pt_base(input int n_words);
        return IDX_KEY_BASE + n_words;
    endfunction

    function automatic int ct_base(input int n_words);
        return IDX_KEY_BASE + 2 * n_words;
    endfunction

endpackage

// File: rtl/mmio_block_cipher_engine_gf_mul8.sv
// rtl/mmio_block_cipher_engine_gf_mul8.sv - combinational GF(2^8) multiplier, AES reduction polynomial
module gf_mul8
    import mmio_bce_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] acc;
    logic [7:0] sh;

    // Shift-and-add: accumulate a*x^i for each set bit of b, reducing a each step
    always_comb begin
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? AES_POLY : 8'h00);
        end
        p = acc;
    end

endmodule

// File: rtl/mmio_block_cipher_engine.sv
// rtl/mmio_block_cipher_engine.sv - memory-mapped byte-lane cipher coprocessor top
module mmio_block_cipher_engine
    import mmio_bce_pkg::*;
#(
    parameter int N_WORDS = 4,
    parameter int LANES   = 1,
    parameter int IDX_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic        accel_select,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [15:0] ctr,
    output logic        irq
);

    localparam int N_BYTES = 4 * N_WORDS;

    localparam logic [IDX_W-1:0] I_CTRL  = IDX_W'(IDX_CTRL);
    localparam logic [IDX_W-1:0] I_COUNT = IDX_W'(IDX_COUNT);
    localparam logic [IDX_W-1:0] I_KEY   = IDX_W'(IDX_KEY_BASE);
    localparam logic [IDX_W-1:0] I_PT    = IDX_W'(pt_base(N_WORDS));
    localparam logic [IDX_W-1:0] I_CT    = IDX_W'(ct_base(N_WORDS));

    logic [31:0] key [N_WORDS];
    logic [31:0] pt  [N_WORDS];
    logic [31:0] ct  [N_WORDS];

    logic        busy;
    logic        done;
    logic        error;
    logic        irq_en;
    logic [1:0]  mode;
    logic [15:0] counter;
    logic [5:0]  idx;

    logic [IDX_W-1:0]   widx;
    logic               wr;
    logic               last;
    logic [N_WORDS-1:0] key_hit;
    logic [N_WORDS-1:0] pt_hit;
    logic [N_WORDS-1:0] ct_hit;
    logic               unused_addr;

    logic [5:0] lane_idx [LANES];
    logic [7:0] lane_a   [LANES];
    logic [7:0] lane_b   [LANES];
    logic [7:0] lane_gf  [LANES];
    logic [7:0] lane_res [LANES];

    assign widx        = addr[IDX_W+1:2];
    assign wr          = wr_en & accel_select;
    assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};
    assign last        = (7'(idx) + 7'(LANES)) == 7'(N_BYTES);
    assign ctr         = counter;
    assign irq         = done & irq_en;

    // Word-register address hits for the KEY, PT and CT windows
    always_comb begin
        for (int w = 0; w < N_WORDS; w++) begin
            key_hit[w] = (widx == I_KEY + IDX_W'(w));
            pt_hit[w]  = (widx == I_PT + IDX_W'(w));
            ct_hit[w]  = (widx == I_CT + IDX_W'(w));
        end
    end

    // Zero-latency read mux; unmapped indices read as zero
    always_comb begin
        data_out = '0;
        if (widx == I_CTRL) begin
            data_out = {done, busy, error, 25'b0, irq_en, mode, 1'b0};
        end else if (widx == I_COUNT) begin
            data_out = {16'b0, counter};
        end
        for (int w = 0; w < N_WORDS; w++) begin
            if (key_hit[w]) data_out = key[w];
            if (pt_hit[w])  data_out = pt[w];
            if (ct_hit[w])  data_out = ct[w];
        end
    end

    // Byte index handled by each lane this cycle
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = idx + 6'(l);
        end
    end

    // Fetch the key and plaintext bytes each lane operates on
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = '0;
            lane_b[l] = '0;
            for (int w = 0; w < N_WORDS; w++) begin
                if (lane_idx[l][5:2] == 4'(w)) begin
                    lane_a[l] = key[w][{lane_idx[l][1:0], 3'b000} +: 8];
                    lane_b[l] = pt[w][{lane_idx[l][1:0], 3'b000} +: 8];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        gf_mul8 u_gf (
            .a (lane_a[l]),
            .b (lane_b[l]),
            .p (lane_gf[l])
        );
    end

    // Per-lane operation select using the mode latched at GO
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            case (mode_e'(mode))
                MODE_MUL: lane_res[l] = lane_a[l] * lane_b[l];
                MODE_GF:  lane_res[l] = lane_gf[l];
                MODE_XOR: lane_res[l] = lane_a[l] ^ lane_b[l];
                default:  lane_res[l] = '0;
            endcase
        end
    end

    // Register writes, GO acceptance/rejection and the byte-walk while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            irq_en  <= 1'b0;
            mode    <= '0;
            counter <= '0;
            idx     <= '0;
            for (int w = 0; w < N_WORDS; w++) begin
                key[w] <= '0;
                pt[w]  <= '0;
                ct[w]  <= '0;
            end
        end else begin
            if (busy) begin
                for (int l = 0; l < LANES; l++) begin
                    for (int w = 0; w < N_WORDS; w++) begin
                        if (lane_idx[l][5:2] == 4'(w)) begin
                            ct[w][{lane_idx[l][1:0], 3'b000} +: 8] <= lane_res[l];
                        end
                    end
                end
                idx     <= idx + 6'(LANES);
                counter <= counter + 16'd1;
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end

            if (wr && widx == I_CTRL) begin
                if (data_in[CTRL_GO]) begin
                    if (!busy && data_in[CTRL_MODE_LSB +: 2] != MODE_RSVD) begin
                        mode    <= data_in[CTRL_MODE_LSB +: 2];
                        irq_en  <= data_in[CTRL_IRQ_EN];
                        counter <= '0;
                        idx     <= '0;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        busy    <= 1'b1;
                        for (int w = 0; w < N_WORDS; w++) begin
                            ct[w] <= '0;
                        end
                    end else begin
                        error <= 1'b1;
                    end
                end else if (!busy) begin
                    mode   <= data_in[CTRL_MODE_LSB +: 2];
                    irq_en <= data_in[CTRL_IRQ_EN];
                end
            end

            for (int w = 0; w < N_WORDS; w++) begin
                if (wr && (key_hit[w] || pt_hit[w])) begin
                    if (busy) begin
                        error <= 1'b1;
                    end else if (key_hit[w]) begin
                        key[w] <= data_in;
                    end else begin
                        pt[w] <= data_in;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_block_cipher_engine.sv
// tb/tb_mmio_block_cipher_engine.sv - randomized self-checking bench for the block cipher engine
module tb_mmio_block_cipher_engine;

    localparam int N   = 4;
    localparam int L   = 1;
    localparam int CYC = 4 * N / L;

    localparam logic [31:0] A_CTRL  = 32'h20;
    localparam logic [31:0] A_COUNT = 32'h24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        wr_en = 1'b0;
    logic        accel_select = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [15:0] ctr;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] key_m [N];
    logic [31:0] pt_m  [N];

    mmio_block_cipher_engine #(.N_WORDS(N), .LANES(L), .IDX_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .wr_en        (wr_en),
        .accel_select (accel_select),
        .data_in      (data_in),
        .data_out     (data_out),
        .ctr          (ctr),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] a_key(input int i);
        return 32'((10 + i) * 4);
    endfunction

    function automatic logic [31:0] a_pt(input int i);
        return 32'((10 + N + i) * 4);
    endfunction

    function automatic logic [31:0] a_ct(input int i);
        return 32'((10 + 2 * N + i) * 4);
    endfunction

    // Carry-less product followed by polynomial long division by 0x11B
    function automatic logic [7:0] ref_gf(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11B << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_op(input int mode, input logic [7:0] a, input logic [7:0] b);
        case (mode)
            0:       return 8'((int'(a) * int'(b)) % 256);
            1:       return ref_gf(a, b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [31:0] exp_ct(input int w, input int mode);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = ref_op(mode, key_m[w][8*b +: 8], pt_m[w][8*b +: 8]);
        return r;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; data_in = d; wr_en = 1'b1; accel_select = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; accel_select = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = data_out;
    endtask

    task automatic wait_idle(output int cycles);
        addr = A_CTRL;
        #1;
        cycles = 0;
        while (data_out[30] && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (data_out[30]) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", cycles);
        end
    endtask

    task automatic load_model();
        for (int w = 0; w < N; w++) begin
            do_write(a_key(w), key_m[w]);
            do_write(a_pt(w), pt_m[w]);
        end
    endtask

    task automatic randomize_model();
        for (int w = 0; w < N; w++) begin
            key_m[w] = $urandom;
            pt_m[w]  = $urandom;
        end
    endtask

    task automatic check_ct_model(input string name, input int mode);
        logic [31:0] d;
        for (int w = 0; w < N; w++) begin
            do_read(a_ct(w), d);
            n_cmp++;
            if (d !== exp_ct(w, mode)) begin
                n_bad++;
                $display("FAIL %s CT[%0d]: got %h required %h", name, w, d, exp_ct(w, mode));
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset CTRL: got %h required 0", d); end
        do_read(A_COUNT, d);
        n_cmp++; if (d !== 32'h0 || ctr !== 16'h0) begin n_bad++; $display("FAIL reset COUNT: got %h/%h required 0", d, ctr); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset irq: got %b required 0", irq); end
        for (int w = 0; w < N; w++) begin
            do_read(a_key(w), d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset KEY[%0d]: got %h required 0", w, d); end
            do_read(a_ct(w), d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset CT[%0d]: got %h required 0", w, d); end
        end
        do_read(32'h0000_0004, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped read: got %h required 0", d); end
    endtask

    task automatic test_vectors();
        logic [31:0] d;
        int cyc;
        for (int w = 0; w < N; w++) begin key_m[w] = '0; pt_m[w] = '0; end
        key_m[0] = 32'h0000_0057; pt_m[0] = 32'h0000_0083;
        key_m[1] = 32'h1300_0000; pt_m[1] = 32'h5700_0000;
        load_model();
        do_write(A_CTRL, 32'h3);
        wait_idle(cyc);
        n_cmp++; if (cyc != CYC) begin n_bad++; $display("FAIL gf busy cycles: got %0d required %0d", cyc, CYC); end
        do_read(A_COUNT, d);
        n_cmp++; if (d !== 32'(CYC)) begin n_bad++; $display("FAIL gf COUNT: got %h required %h", d, CYC); end
        do_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h8000_0002) begin n_bad++; $display("FAIL gf CTRL: got %h required 80000002", d); end
        do_read(a_ct(0), d);
        n_cmp++; if (d !== 32'h0000_00C1) begin n_bad++; $display("FAIL gf CT0: got %h required 000000c1", d); end
        do_read(a_ct(1), d);
        n_cmp++; if (d !== 32'hFE00_0000) begin n_bad++; $display("FAIL gf CT1: got %h required fe000000", d); end
        do_write(A_CTRL, 32'h1);
        wait_idle(cyc);
        do_read(a_ct(0), d);
        n_cmp++; if (d !== 32'h0000_0085) begin n_bad++; $display("FAIL mul CT0: got %h required 00000085", d); end
        do_read(a_ct(1), d);
        n_cmp++; if (d !== 32'h7500_0000) begin n_bad++; $display("FAIL mul CT1: got %h required 75000000", d); end
        do_write(A_CTRL, 32'h5);
        wait_idle(cyc);
        do_read(a_ct(0), d);
        n_cmp++; if (d !== 32'h0000_00D4) begin n_bad++; $display("FAIL xor CT0: got %h required 000000d4", d); end
        do_read(a_ct(1), d);
        n_cmp++; if (d !== 32'h4400_0000) begin n_bad++; $display("FAIL xor CT1: got %h required 44000000", d); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int cyc;
        int mode;
        for (int it = 0; it < 6; it++) begin
            randomize_model();
            mode = int'($urandom_range(0, 2));
            load_model();
            do_write(A_CTRL, 32'(mode << 1) | 32'h1);
            wait_idle(cyc);
            n_cmp++; if (cyc != CYC) begin n_bad++; $display("FAIL random busy cycles: got %0d required %0d", cyc, CYC); end
            n_cmp++; if (ctr !== 16'(CYC)) begin n_bad++; $display("FAIL random ctr: got %0d required %0d", ctr, CYC); end
            do_read(A_CTRL, d);
            n_cmp++; if (d !== (32'h8000_0000 | 32'(mode << 1))) begin n_bad++; $display("FAIL random CTRL: got %h mode %0d", d, mode); end
            check_ct_model("random", mode);
        end
    endtask

    task automatic test_go_while_busy();
        logic [31:0] d;
        int cyc;
        randomize_model();
        load_model();
        do_write(A_CTRL, 32'h1);
        repeat (2) @(posedge clk);
        do_write(A_CTRL, 32'h5);
        do_write(a_pt(0), ~pt_m[0]);
        do_read(A_CTRL, d);
        n_cmp++; if (d[31:29] !== 3'b011) begin n_bad++; $display("FAIL busy reject status: got %b required 011", d[31:29]); end
        wait_idle(cyc);
        do_read(A_COUNT, d);
        n_cmp++; if (d !== 32'(CYC)) begin n_bad++; $display("FAIL busy reject COUNT: got %h required %h", d, CYC); end
        do_read(a_pt(0), d);
        n_cmp++; if (d !== pt_m[0]) begin n_bad++; $display("FAIL busy reject PT0: got %h required %h", d, pt_m[0]); end
        check_ct_model("busy_reject", 0);
        do_read(A_CTRL, d);
        n_cmp++; if (d[29] !== 1'b1) begin n_bad++; $display("FAIL error sticky: got %b required 1", d[29]); end
        do_write(A_CTRL, 32'h5);
        do_read(A_CTRL, d);
        n_cmp++; if (d[31:29] !== 3'b010) begin n_bad++; $display("FAIL go clears error: got %b required 010", d[31:29]); end
        wait_idle(cyc);
        check_ct_model("after_reject", 2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        randomize_model();
        load_model();
        do_write(A_CTRL, 32'h3);
        repeat (CYC - 1) @(posedge clk);
        do_write(A_CTRL, 32'h5);
        do_read(A_CTRL, d);
        n_cmp++; if (d[31:29] !== 3'b101) begin n_bad++; $display("FAIL go on last edge: got %b required 101", d[31:29]); end
        do_read(A_COUNT, d);
        n_cmp++; if (d !== 32'(CYC)) begin n_bad++; $display("FAIL go on last edge COUNT: got %h required %h", d, CYC); end
        check_ct_model("last_edge", 1);
    endtask

    task automatic test_mode3_and_ct_write();
        logic [31:0] d;
        int cyc;
        do_write(A_CTRL, 32'h7);
        do_read(A_CTRL, d);
        n_cmp++; if (d[31:29] !== 3'b101) begin n_bad++; $display("FAIL mode3 reject: got %b required 101", d[31:29]); end
        check_ct_model("mode3", 1);
        do_write(A_CTRL, 32'h1);
        wait_idle(cyc);
        do_write(a_ct(0), 32'hDEAD_BEEF);
        do_read(A_CTRL, d);
        n_cmp++; if (d[29] !== 1'b0) begin n_bad++; $display("FAIL ct write error: got %b required 0", d[29]); end
        check_ct_model("ct_write", 0);
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int cyc;
        randomize_model();
        load_model();
        do_write(A_CTRL, 32'hB);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq while busy: got %b required 0", irq); end
        wait_idle(cyc);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq at done: got %b required 1", irq); end
        do_write(A_CTRL, 32'hB);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq after new go: got %b required 0", irq); end
        wait_idle(cyc);
        do_write(A_CTRL, 32'h4);
        do_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h8000_0004 || irq !== 1'b0) begin n_bad++; $display("FAIL idle ctrl write: got %h irq %b required 80000004 irq 0", d, irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int cyc;
        randomize_model();
        load_model();
        do_write(A_CTRL, 32'h3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        do_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid reset CTRL: got %h required 0", d); end
        do_read(A_COUNT, d);
        n_cmp++; if (d !== 32'h0 || ctr !== 16'h0) begin n_bad++; $display("FAIL mid reset COUNT: got %h required 0", d); end
        for (int w = 0; w < N; w++) begin
            do_read(a_key(w), d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid reset KEY[%0d]: got %h required 0", w, d); end
            do_read(a_pt(w), d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid reset PT[%0d]: got %h required 0", w, d); end
            do_read(a_ct(w), d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid reset CT[%0d]: got %h required 0", w, d); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        randomize_model();
        load_model();
        do_write(A_CTRL, 32'h3);
        wait_idle(cyc);
        n_cmp++; if (cyc != CYC) begin n_bad++; $display("FAIL post reset cycles: got %0d required %0d", cyc, CYC); end
        check_ct_model("post_reset", 1);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_go_while_busy();
        test_back_to_back();
        test_mode3_and_ct_write();
        test_irq();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
